// File: rtl/mult4_share_arb.sv
// mult4_share_arb: shares one 4x4 unsigned multiplier among NUM_REQ requesters.
// Requests are arbitrated round-robin, registered in stage A (operands), and the
// product is registered in stage B before being returned to the originating
// requester. Define MULT4_ARB_FIXED_PRIO_EN to select fixed lowest-index
// priority instead of round-robin; the pipeline behaves identically either way.

module multiplier_8bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] out
);
  assign out = {4'b0000, x} * {4'b0000, y};
endmodule

module mult4_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_x,
  input  logic [4*NUM_REQ-1:0] req_y,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_prod,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic                 busy
);

  // Stage A: operand register feeding the shared multiplier
  logic             a_valid_q, a_valid_d;
  logic [3:0]       a_x_q, a_x_d;
  logic [3:0]       a_y_q, a_y_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;

  // Stage B: registered product and the tag of its owner
  logic             b_valid_q, b_valid_d;
  logic [7:0]       b_prod_q, b_prod_d;
  logic [TAG_W-1:0] b_tag_q, b_tag_d;

  // Arbitration state and per-cycle control
  logic [TAG_W-1:0] rr_ptr_q;
  logic [TAG_W-1:0] grant_s;
  logic             grant_found_s;
  logic [3:0]       grant_x_s;
  logic [3:0]       grant_y_s;
  logic             drain_s;
  logic             b_free_s;
  logic             advance_s;
  logic             a_free_s;
  logic             accept_s;
  logic [7:0]       mult_out_s;
  int               best_dist_s;
  int               dist_s;
  logic             take_s;

  multiplier_8bit u_mult (
    .x   (a_x_q),
    .y   (a_y_q),
    .out (mult_out_s)
  );

  // Pipeline handshakes: B drains to its owner, A moves into a free B
  assign drain_s   = b_valid_q && rsp_ready[b_tag_q];
  assign b_free_s  = !b_valid_q || drain_s;
  assign advance_s = a_valid_q && b_free_s;
  assign a_free_s  = !a_valid_q || advance_s;
  assign accept_s  = grant_found_s && a_free_s;

  // Grant the valid requester closest to rr_ptr going upward with wrap
  always_comb begin
    best_dist_s   = NUM_REQ;
    dist_s        = 0;
    take_s        = 1'b0;
    grant_s       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s      = (i >= int'(rr_ptr_q)) ? (i - int'(rr_ptr_q))
                                          : (i + NUM_REQ - int'(rr_ptr_q));
      take_s      = req_valid[i] && (dist_s < best_dist_s);
      best_dist_s = take_s ? dist_s : best_dist_s;
      grant_s     = take_s ? TAG_W'(i) : grant_s;
    end
    grant_found_s = (best_dist_s < NUM_REQ);
  end

  // Select the granted requester's operands
  always_comb begin
    grant_x_s = 4'h0;
    grant_y_s = 4'h0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_x_s = (grant_s == TAG_W'(i)) ? req_x[4*i +: 4] : grant_x_s;
      grant_y_s = (grant_s == TAG_W'(i)) ? req_y[4*i +: 4] : grant_y_s;
    end
  end

  // Decode one-hot ready and response-valid vectors
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept_s && (grant_s == TAG_W'(i));
      rsp_valid[i] = b_valid_q && (b_tag_q == TAG_W'(i));
    end
  end

  assign rsp_prod = b_prod_q;
  assign busy     = a_valid_q || b_valid_q;

  // Next-state for both pipeline stages
  always_comb begin
    a_valid_d = a_valid_q;
    a_x_d     = a_x_q;
    a_y_d     = a_y_q;
    a_tag_d   = a_tag_q;
    b_valid_d = b_valid_q;
    b_prod_d  = b_prod_q;
    b_tag_d   = b_tag_q;

    if (advance_s) begin
      b_valid_d = 1'b1;
      b_prod_d  = mult_out_s;
      b_tag_d   = a_tag_q;
    end else if (drain_s) begin
      b_valid_d = 1'b0;
    end else begin
      b_valid_d = b_valid_q;
    end

    if (accept_s) begin
      a_valid_d = 1'b1;
      a_x_d     = grant_x_s;
      a_y_d     = grant_y_s;
      a_tag_d   = grant_s;
    end else if (advance_s) begin
      a_valid_d = 1'b0;
    end else begin
      a_valid_d = a_valid_q;
    end
  end

  // Pipeline registers with synchronous reset; in-flight work is discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_x_q     <= 4'h0;
      a_y_q     <= 4'h0;
      a_tag_q   <= '0;
      b_valid_q <= 1'b0;
      b_prod_q  <= 8'h00;
      b_tag_q   <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_x_q     <= a_x_d;
      a_y_q     <= a_y_d;
      a_tag_q   <= a_tag_d;
      b_valid_q <= b_valid_d;
      b_prod_q  <= b_prod_d;
      b_tag_q   <= b_tag_d;
    end
  end

`ifdef MULT4_ARB_FIXED_PRIO_EN
  // Fixed priority: scan always starts at requester 0
  assign rr_ptr_q = '0;
`else
  logic [TAG_W-1:0] rr_ptr_d;

  // Index after g, wrapping at NUM_REQ
  function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] g);
    if (g == TAG_W'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return g + TAG_W'(1);
    end
  endfunction

  // Pointer moves past the winner only when a request is accepted
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_s) begin
      rr_ptr_d = next_ptr(grant_s);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_mult4_share_arb.sv
// Self-checking bench for mult4_share_arb: directed sequences, a corner-operand
// vector table, and randomized traffic checked every cycle against a
// transaction-level model (a FIFO of in-flight operations, capacity two).
module tb_mult4_share_arb;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4*N-1:0] req_x, req_y;
  logic [7:0]     rsp_prod;
  logic           busy;

  mult4_share_arb #(.NUM_REQ(N), .TAG_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_prod(rsp_prod),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int tag; int prod; int age; } op_t;
  typedef struct { logic [3:0] x; logic [3:0] y; } pair_t;
  typedef struct { logic [3:0] x; logic [3:0] y; int prod; } vec_t;

  op_t   q[$];          // in-flight operations, oldest first
  pair_t pend[N][$];    // per-requester operations waiting to be accepted
  int    log_tag[$], log_prod[$], log_cyc[$];
  int    checks, errors, cyc, acc_cyc, m_ptr, m_grant;
  bit    m_found, m_head_ok, m_drain, m_afree, m_accept;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pend_any();
    for (int i = 0; i < N; i++) if (pend[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_logs();
    log_tag.delete(); log_prod.delete(); log_cyc.delete();
  endtask

  // First half of a cycle: drive requests, then compare against the model
  task automatic cycle_a();
    int j;
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() != 0) begin
        req_valid[i] = 1'b1; req_x[4*i +: 4] = pend[i][0].x; req_y[4*i +: 4] = pend[i][0].y;
      end else begin
        req_valid[i] = 1'b0; req_x[4*i +: 4] = 4'h0; req_y[4*i +: 4] = 4'h0;
      end
    end
    @(negedge clk);
    m_found = 1'b0; m_grant = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (m_ptr + k) % N;
      if (pend[j].size() != 0) begin m_found = 1'b1; m_grant = j; end
    end
    m_head_ok = (q.size() != 0) && (q[0].age >= 1);
    m_drain   = m_head_ok && rsp_ready[q[0].tag];
    m_afree   = (q.size() < 2) || m_drain;
    m_accept  = m_found && m_afree;
    chk("req_ready", 32'(req_ready), m_accept ? (32'd1 << m_grant) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), m_head_ok ? (32'd1 << q[0].tag) : 32'd0);
    if (m_head_ok) chk("rsp_prod", 32'(rsp_prod), 32'(q[0].prod));
    chk("busy", 32'(busy), 32'(q.size() != 0));
  endtask

  // Second half: clock edge, then advance the model
  task automatic cycle_b();
    pair_t p;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ptr = 0;
    end else begin
      if (m_drain) begin
        log_tag.push_back(q[0].tag); log_prod.push_back(q[0].prod); log_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
      if (m_accept) begin
        p = pend[m_grant].pop_front();
        q.push_back('{m_grant, int'(p.x) * int'(p.y), 0});
        acc_cyc = cyc;
`ifndef MULT4_ARB_FIXED_PRIO_EN
        m_ptr = (m_grant + 1) % N;
`endif
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((q.size() != 0 || pend_any()) && n < budget) begin
      cycle_a(); cycle_b(); n++;
    end
    chk("idle_reached", 32'(q.size() == 0 && !pend_any()), 32'd1);
  endtask

  function automatic pair_t rnd_pair();
    pair_t p;
    p.x = 4'($urandom_range(0, 15));
    p.y = 4'($urandom_range(0, 15));
    return p;
  endfunction

  vec_t tbl[4];
  int   exp_tags[$];
  int   prodq[N][$];
  pair_t pr;

  initial begin
    checks = 0; errors = 0; cyc = 0; acc_cyc = 0; m_ptr = 0;
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_prod", 32'(rsp_prod), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Single request: 3*5 from requester 0
    clear_logs(); rsp_ready = '1;
    pend[0].push_back('{4'd3, 4'd5});
    cycle_a(); chk("single_ready", 32'(req_ready), 32'd1); cycle_b();
    run_idle(20);
    chk("single_count", 32'(log_tag.size()), 32'd1);
    if (log_tag.size() == 1) begin
      chk("single_tag", 32'(log_tag[0]), 32'd0);
      chk("single_prod", 32'(log_prod[0]), 32'd15);
      chk("single_latency", 32'(log_cyc[0] - acc_cyc), 32'd2);
    end
    chk("single_busy_end", 32'(busy), 32'd0);

    // Corner operands back-to-back from requester 1
    tbl[0] = '{4'd15, 4'd15, 225};
    tbl[1] = '{4'd0,  4'd9,  0};
    tbl[2] = '{4'd1,  4'd15, 15};
    tbl[3] = '{4'd8,  4'd2,  16};
    clear_logs();
    for (int i = 0; i < 4; i++) pend[1].push_back('{tbl[i].x, tbl[i].y});
    run_idle(30);
    chk("corner_count", 32'(log_tag.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_tag.size(); i++) begin
      chk("corner_tag", 32'(log_tag[i]), 32'd1);
      chk("corner_prod", 32'(log_prod[i]), 32'(tbl[i].prod));
      if (i > 0) chk("corner_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
    end

    // Contention from reset: every requester has two operations queued
    rst = 1'b1; cycle_a(); cycle_b(); rst = 1'b0;
    clear_logs(); exp_tags.delete();
    for (int r = 0; r < N; r++) begin
      prodq[r].delete();
      for (int k = 0; k < 2; k++) begin
        pr = rnd_pair(); pend[r].push_back(pr); prodq[r].push_back(int'(pr.x) * int'(pr.y));
      end
    end
`ifdef MULT4_ARB_FIXED_PRIO_EN
    for (int r = 0; r < N; r++) begin exp_tags.push_back(r); exp_tags.push_back(r); end
`else
    for (int k = 0; k < 2; k++) for (int r = 0; r < N; r++) exp_tags.push_back(r);
`endif
    run_idle(40);
    chk("contend_count", 32'(log_tag.size()), 32'(exp_tags.size()));
    for (int i = 0; i < exp_tags.size() && i < log_tag.size(); i++) begin
      chk("contend_tag", 32'(log_tag[i]), 32'(exp_tags[i]));
      if (prodq[log_tag[i]].size() != 0)
        chk("contend_prod", 32'(log_prod[i]), 32'(prodq[log_tag[i]].pop_front()));
    end

`ifdef MULT4_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 3 waits until requester 0 goes idle
    clear_logs();
    for (int k = 0; k < 3; k++) pend[0].push_back(rnd_pair());
    pend[3].push_back(rnd_pair());
    run_idle(20);
    chk("fixed_count", 32'(log_tag.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_tag.size(); i++)
      chk("fixed_tag", 32'(log_tag[i]), (i < 3) ? 32'd0 : 32'd3);
`endif

    // Backpressure: 7*6 for requester 2 held while requester 3 waits
    clear_logs(); rsp_ready = 4'b1011;
    pend[2].push_back('{4'd7, 4'd6});
    cycle_a(); cycle_b();
    pend[3].push_back(rnd_pair()); pend[3].push_back(rnd_pair());
    cycle_a(); cycle_b();
    for (int s = 0; s < 5; s++) begin
      cycle_a();
      chk("bp_prod", 32'(rsp_prod), 32'd42);
      chk("bp_valid", 32'(rsp_valid), 32'd4);
      chk("bp_ready", 32'(req_ready), 32'd0);
      cycle_b();
    end
    rsp_ready = '1;
    run_idle(20);
    chk("bp_count", 32'(log_tag.size()), 32'd3);
    if (log_tag.size() == 3) begin
      chk("bp_first_tag", 32'(log_tag[0]), 32'd2);
      chk("bp_first_prod", 32'(log_prod[0]), 32'd42);
      chk("bp_second_tag", 32'(log_tag[1]), 32'd3);
      chk("bp_third_tag", 32'(log_tag[2]), 32'd3);
    end

    // Reset while both stages hold data
    clear_logs(); rsp_ready = '0;
    pend[1].push_back(rnd_pair()); pend[2].push_back(rnd_pair());
    cycle_a(); cycle_b(); cycle_a(); cycle_b();
    rst = 1'b1; cycle_a(); cycle_b(); rst = 1'b0;
    for (int r = 0; r < N; r++) pend[r].delete();
    cycle_a();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_prod", 32'(rsp_prod), 32'd0);
    cycle_b();
    rsp_ready = '1;
    pend[3].push_back(rnd_pair()); pend[1].push_back(rnd_pair());
    cycle_a(); chk("rst_first_grant", 32'(req_ready), 32'd2); cycle_b();
    run_idle(20);
    chk("rst_count", 32'(log_tag.size()), 32'd2);
    if (log_tag.size() == 2) begin
      chk("rst_tag0", 32'(log_tag[0]), 32'd1);
      chk("rst_tag1", 32'(log_tag[1]), 32'd3);
    end

    // Randomized traffic with random response backpressure
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < N; r++)
        if (pend[r].size() == 0 && $urandom_range(0, 2) == 0) pend[r].push_back(rnd_pair());
      rsp_ready = 4'($urandom);
      cycle_a(); cycle_b();
    end
    rsp_ready = '1;
    run_idle(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
